// File: rtl/alu_pkg.sv
// Shared ALU control code map and multiply/divide FSM state encoding
// for the multicycle MIPS datapath.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_MULT  = 4'd3;
    localparam logic [3:0] ALU_MULTU = 4'd4;
    localparam logic [3:0] ALU_DIV   = 4'd5;
    localparam logic [3:0] ALU_DIVU  = 4'd6;
    localparam logic [3:0] ALU_SUB   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_XOR   = 4'd10;
    localparam logic [3:0] ALU_NOR   = 4'd11;
    localparam logic [3:0] ALU_SLL   = 4'd12;
    localparam logic [3:0] ALU_SRL   = 4'd13;
    localparam logic [3:0] ALU_SRA   = 4'd14;
    localparam logic [3:0] ALU_LUI   = 4'd15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic is_mdu_op(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_MULTU) ||
               (code == ALU_DIV)  || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration on the {rem,acc} pair: shift-add for multiply
// (acc holds the multiplier) or restoring shift-subtract for divide (acc holds the dividend).
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_sum   = {1'b0, i_rem} + {1'b0, i_opnd};
    assign w_shift = {i_rem, i_acc[WIDTH-1]};
    // Partial remainder stays below the divisor, so the difference always fits WIDTH bits.
    assign w_diff  = w_shift[WIDTH-1:0] - i_opnd;

    always_comb begin
        o_rem = i_rem;
        o_acc = i_acc;
        if (i_div) begin
            if (w_shift >= {1'b0, i_opnd}) begin
                o_rem = w_diff;
                o_acc = {i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_rem = w_shift[WIDTH-1:0];
                o_acc = {i_acc[WIDTH-2:0], 1'b0};
            end
        end else if (i_acc[0]) begin
            o_rem = w_sum[WIDTH:1];
            o_acc = {w_sum[0], i_acc[WIDTH-1:1]};
        end else begin
            o_rem = {1'b0, i_rem[WIDTH-1:1]};
            o_acc = {i_rem[0], i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and start/busy/done handshake.
// Optional macro MDU_FAST_MUL_EN: single-cycle multiply path, divide stays iterative.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_rem, r_acc, r_opnd, r_hi, r_lo;
    logic               r_done;

    logic               w_accept, w_iter_accept, w_is_div, w_signed, w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_rem_nxt, w_acc_nxt;
    logic [WIDTH-1:0]   w_quot, w_remd, w_res_hi, w_res_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = start && (r_state == S_IDLE) && is_mdu_op(op);

    assign w_is_div = (r_op == ALU_DIV) || (r_op == ALU_DIVU);
    assign w_signed = (r_op == ALU_MULT) || (r_op == ALU_DIV);
    assign w_sa     = w_signed & r_a[WIDTH-1];
    assign w_sb     = w_signed & r_b[WIDTH-1];
    assign w_mag_a  = w_sa ? (~r_a + 1'b1) : r_a;
    assign w_mag_b  = w_sb ? (~r_b + 1'b1) : r_b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (w_is_div),
        .i_rem  (r_rem),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_rem  (w_rem_nxt),
        .o_acc  (w_acc_nxt)
    );

    // Sign correction on the magnitude results; |MIN|/1 negates back to MIN on its own.
    assign w_prod = (w_sa ^ w_sb) ? (~{r_rem, r_acc} + 1'b1) : {r_rem, r_acc};
    assign w_quot = (w_sa ^ w_sb) ? (~r_acc + 1'b1) : r_acc;
    assign w_remd = w_sa ? (~r_rem + 1'b1) : r_rem;

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (w_is_div) begin
            if (r_b == '0) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_remd;
                w_res_lo = w_quot;
            end
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic               w_is_mul_in;
    logic               r_fast_pend, r_fast_signed;
    logic [WIDTH-1:0]   r_fa, r_fb;
    logic [2*WIDTH-1:0] w_fprod;

    assign w_is_mul_in   = (op == ALU_MULT) || (op == ALU_MULTU);
    assign w_iter_accept = w_accept & ~w_is_mul_in;
    assign w_fprod = r_fast_signed
        ? ({{WIDTH{r_fa[WIDTH-1]}}, r_fa} * {{WIDTH{r_fb[WIDTH-1]}}, r_fb})
        : ({{WIDTH{1'b0}}, r_fa} * {{WIDTH{1'b0}}, r_fb});
`else
    assign w_iter_accept = w_accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
`ifdef MDU_FAST_MUL_EN
            r_fast_pend   <= 1'b0;
            r_fast_signed <= 1'b0;
            r_fa          <= '0;
            r_fb          <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_iter_accept) begin
                        r_state <= S_RUN;
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    // Count 0 loads magnitudes; counts 1..WIDTH each perform one step.
                    if (r_cnt == '0) begin
                        r_rem  <= '0;
                        r_acc  <= w_mag_a;
                        r_opnd <= w_mag_b;
                        r_cnt  <= r_cnt + 1'b1;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_acc <= w_acc_nxt;
                        if (r_cnt == CW'(WIDTH)) begin
                            r_state <= S_FIX;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef MDU_FAST_MUL_EN
            r_fast_pend <= w_accept & w_is_mul_in;
            if (w_accept & w_is_mul_in) begin
                r_fa          <= a;
                r_fb          <= b;
                r_fast_signed <= (op == ALU_MULT);
            end
            if (r_fast_pend) begin
                r_hi   <= w_fprod[2*WIDTH-1:WIDTH];
                r_lo   <= w_fprod[WIDTH-1:0];
                r_done <= 1'b1;
            end
`endif
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [3:0]  op8 = 4'd0;
    logic [7:0]  a8 = '0, b8 = '0, wdata8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(wdata8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        h = '0; l = '0;
        case (o)
            4'd3: begin p = longint'(sx * sy); h = p[63:32]; l = p[31:0]; end
            4'd4: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
            4'd5: begin
                if (y == 0) begin h = x; l = '1; end
                else begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            end
            default: begin
                if (y == 0) begin h = x; l = '1; end
                else begin p = ux / uy; h = 32'(ux % uy); l = p[31:0]; end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
`ifdef MDU_FAST_MUL_EN
        if (o == 4'd3 || o == 4'd4) return 1;
`endif
        return 34;
    endfunction

    // Called just after a rising edge; returns edges from the sampling edge to done.
    task automatic run_op(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          output logic [31:0] t_hi, output logic [31:0] t_lo, output int t_lat);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t_lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin t_lat = i + 1; break; end
        end
        t_hi = hi; t_lo = lo;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", t_op, t_a, t_b, t_hi, t_lo, t_lat);
    endtask

    task automatic check_op(input string name, input logic [3:0] t_op,
                            input logic [31:0] t_a, input logic [31:0] t_b);
        logic [31:0] g_hi, g_lo, e_hi, e_lo;
        int lat;
        ref_op(t_op, t_a, t_b, e_hi, e_lo);
        run_op(t_op, t_a, t_b, g_hi, g_lo, lat);
        n_checks++;
        if (g_hi !== e_hi || g_lo !== e_lo || lat != exp_lat(t_op)) begin
            n_errors++;
            $display("FAIL %s: got hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=%0d",
                     name, g_hi, g_lo, lat, e_hi, e_lo, exp_lat(t_op));
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy, done, hi, lo, busy8, done8, hi8, lo8} !== '0) begin
            n_errors++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("multu_max_x2", 4'd4, 32'hFFFF_FFFF, 32'd2);
        check_op("mult_neg3_5", 4'd3, 32'hFFFF_FFFD, 32'd5);
        check_op("div_neg7_2", 4'd5, 32'hFFFF_FFF9, 32'd2);
        check_op("divu_by_zero", 4'd6, 32'd7, 32'd0);
        check_op("div_by_zero_neg", 4'd5, 32'hFFFF_FF00, 32'd0);
        check_op("div_min_m1", 4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("mult_min_min", 4'd3, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_width8();
        int lat;
        op8 = 4'd5; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done8) begin lat = i + 1; break; end
        end
        $display("w8 op=5 a=80 b=ff -> hi=%h lo=%h lat=%0d", hi8, lo8, lat);
        n_checks++;
        if (lo8 !== 8'h80 || hi8 !== 8'h00 || lat != 10) begin
            n_errors++;
            $display("FAIL w8_div_min_m1: got hi=%h lo=%h lat=%0d, expected hi=00 lo=80 lat=10", hi8, lo8, lat);
        end
    endtask

    task automatic test_mthi_mtlo_stale();
        logic [31:0] e_hi, e_lo;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h, expected 12345678", hi, lo);
        end
        // MTLO on the same edge a divide is accepted.
        op = 4'd6; a = 32'd1000; b = 32'd9; start = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        n_checks++;
        if (lo !== 32'hCAFE_0001 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mtlo_with_start: got lo=%h busy=%b, expected lo=cafe0001 busy=1", lo, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_0001) begin
            n_errors++;
            $display("FAIL stale_during_busy: got hi=%h lo=%h, expected hi=12345678 lo=cafe0001", hi, lo);
        end
        for (int i = 0; i < 60 && !done; i++) begin @(posedge clk); #1; end
        ref_op(4'd6, 32'd1000, 32'd9, e_hi, e_lo);
        n_checks++;
        if (done !== 1'b1 || hi !== e_hi || lo !== e_lo) begin
            n_errors++;
            $display("FAIL divu_after_mtlo: got done=%b hi=%h lo=%h, expected done=1 hi=%h lo=%h", done, hi, lo, e_hi, e_lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_while_busy();
        int lat;
        op = 4'd6; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        op = 4'd3; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i + 7; break; end
        end
        $display("op=6 a=100 b=7 (disturbed) -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        n_checks++;
        if (lo !== 32'd14 || hi !== 32'd2 || lat != 34) begin
            n_errors++;
            $display("FAIL ignore_while_busy: got hi=%h lo=%h lat=%0d, expected hi=2 lo=14 lat=34", hi, lo, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid_op();
        logic [31:0] old_hi, old_lo;
        old_hi = hi; old_lo = lo;
        op = 4'd7; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== old_hi || lo !== old_lo) begin
            n_errors++;
            $display("FAIL invalid_op: got busy=%b done=%b hi=%h lo=%h, expected 0 0 %h %h", busy, done, hi, lo, old_hi, old_lo);
        end
    endtask

    task automatic test_random();
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;
        for (int n = 0; n < 40; n++) begin
            r_op = 4'($urandom_range(3, 6));
            r_a  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 20));
                2: r_b = 32'hFFFF_FFFF;
                3: r_b = -32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) r_a = 32'h8000_0000;
            check_op("random", r_op, r_a, r_b);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] g_hi, g_lo;
        int lat;
        op = 4'd5; a = 32'hFFFF_FF9C; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd4, 32'd6, 32'd7, g_hi, g_lo, lat);
        n_checks++;
        if (g_lo !== 32'd42 || g_hi !== 32'd0 || lat != exp_lat(4'd4)) begin
            n_errors++;
            $display("FAIL after_reset_multu: got hi=%h lo=%h lat=%0d, expected hi=0 lo=42 lat=%0d", g_hi, g_lo, lat, exp_lat(4'd4));
        end
    endtask

`ifdef MDU_FAST_MUL_EN
    task automatic test_fast_mul();
        op = 4'd4; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL fast_mul_busy: got busy=%b, expected 0", busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'd42 || hi !== 32'd0) begin
            n_errors++;
            $display("FAIL fast_mul: got done=%b busy=%b hi=%h lo=%h, expected 1 0 0 42", done, busy, hi, lo);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_width8();
        test_mthi_mtlo_stale();
        test_ignore_while_busy();
        test_invalid_op();
        test_random();
        test_async_reset();
`ifdef MDU_FAST_MUL_EN
        test_fast_mul();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
